// File: rtl/adc_min_window_monitor_if.sv
// Control/data bundle between a controller and adc_min_window_monitor.
// Optional max-tracking signals exist only when ADC_MIN_WINDOW_MAX_EN is defined.
interface adc_min_window_monitor_if #(
  parameter int ADC_DATA_WIDTH = 8,
  parameter int WIN_CNT_WIDTH  = 24,
  parameter int WIN_NUM_WIDTH  = 16
);
  logic [ADC_DATA_WIDTH-1:0] adc_min_i;
  logic [WIN_CNT_WIDTH-1:0]  win_len_i;
  logic [ADC_DATA_WIDTH-1:0] thresh_i;
  logic                      start_i;
  logic                      stop_i;
  logic                      continuous_i;
  logic                      alarm_clr_i;
  logic                      busy_o;
  logic [ADC_DATA_WIDTH-1:0] min_hold_o;
  logic                      min_valid_o;
  logic                      alarm_o;
  logic [WIN_NUM_WIDTH-1:0]  win_num_o;
`ifdef ADC_MIN_WINDOW_MAX_EN
  logic [ADC_DATA_WIDTH-1:0] thresh_hi_i;
  logic [ADC_DATA_WIDTH-1:0] max_hold_o;
  logic                      over_alarm_o;
`endif

  modport master (
    output adc_min_i, win_len_i, thresh_i, start_i, stop_i, continuous_i, alarm_clr_i,
`ifdef ADC_MIN_WINDOW_MAX_EN
    output thresh_hi_i,
    input  max_hold_o, over_alarm_o,
`endif
    input  busy_o, min_hold_o, min_valid_o, alarm_o, win_num_o
  );

  modport slave (
    input  adc_min_i, win_len_i, thresh_i, start_i, stop_i, continuous_i, alarm_clr_i,
`ifdef ADC_MIN_WINDOW_MAX_EN
    input  thresh_hi_i,
    output max_hold_o, over_alarm_o,
`endif
    output busy_o, min_hold_o, min_valid_o, alarm_o, win_num_o
  );
endinterface

// File: rtl/adc_min_window_monitor.sv
// Windowed minimum of the per-clock ADC minimum stream with valid strobe, window count and
// sticky under-range alarm. Define ADC_MIN_WINDOW_MAX_EN to add windowed maximum and over-range alarm.
module adc_min_window_monitor #(
  parameter int ADC_DATA_WIDTH = 8,
  parameter int WIN_CNT_WIDTH  = 24,
  parameter int SKIP_CYCLES    = 3,
  parameter int WIN_NUM_WIDTH  = 16
) (
  input logic                     clk,
  input logic                     rst,
  adc_min_window_monitor_if.slave bus
);

  localparam int SKIP_W = (SKIP_CYCLES > 1) ? $clog2(SKIP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SKIP  = 2'd1,
    S_ACCUM = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic                      w_latch;
  logic                      w_commit;
  logic [WIN_CNT_WIDTH-1:0]  w_len;
  logic                      w_alarm_set;

  logic [SKIP_W-1:0]         r_skip_cnt;
  logic [WIN_CNT_WIDTH-1:0]  r_cnt;
  logic                      r_first;
  logic [ADC_DATA_WIDTH-1:0] r_run_min;
  logic                      r_busy;
  logic [ADC_DATA_WIDTH-1:0] r_min_hold;
  logic                      r_min_valid;
  logic                      r_alarm;
  logic [WIN_NUM_WIDTH-1:0]  r_win_num;

  function automatic logic [ADC_DATA_WIDTH-1:0] f_min(input logic [ADC_DATA_WIDTH-1:0] a,
                                                      input logic [ADC_DATA_WIDTH-1:0] b);
    return (b < a) ? b : a;
  endfunction

  function automatic logic [ADC_DATA_WIDTH-1:0] f_max(input logic [ADC_DATA_WIDTH-1:0] a,
                                                      input logic [ADC_DATA_WIDTH-1:0] b);
    return (b > a) ? b : a;
  endfunction

  // A zero length would never terminate the down-counter, so it is promoted to one clock.
  assign w_len = (bus.win_len_i == '0) ? WIN_CNT_WIDTH'(1) : bus.win_len_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_latch  = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start_i) begin
          w_latch = 1'b1;
          w_next  = (SKIP_CYCLES > 0) ? S_SKIP : S_ACCUM;
        end
      end
      S_SKIP: begin
        if (bus.stop_i) begin
          w_next = S_IDLE;
        end else if (r_skip_cnt == SKIP_W'(1)) begin
          w_next = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (bus.stop_i) begin
          w_next = S_IDLE;
        end else if (r_cnt == WIN_CNT_WIDTH'(1)) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        // Abort outranks completion: a stop in DONE drops the window entirely.
        if (bus.stop_i) begin
          w_next = S_IDLE;
        end else begin
          w_commit = 1'b1;
          if (bus.continuous_i) begin
            w_latch = 1'b1;
            w_next  = S_ACCUM;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_alarm_set = w_commit && (r_run_min < bus.thresh_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_skip_cnt <= '0;
      r_cnt      <= '0;
      r_first    <= 1'b0;
      r_run_min  <= '0;
    end else begin
      if (w_latch) begin
        r_cnt      <= w_len;
        r_skip_cnt <= SKIP_W'(SKIP_CYCLES);
        r_first    <= 1'b1;
      end else if (r_state == S_SKIP) begin
        r_skip_cnt <= r_skip_cnt - SKIP_W'(1);
      end else if (r_state == S_ACCUM) begin
        r_cnt   <= r_cnt - WIN_CNT_WIDTH'(1);
        r_first <= 1'b0;
      end
      if (r_state == S_ACCUM) begin
        r_run_min <= r_first ? bus.adc_min_i : f_min(r_run_min, bus.adc_min_i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy      <= 1'b0;
      r_min_hold  <= '1;
      r_min_valid <= 1'b0;
      r_alarm     <= 1'b0;
      r_win_num   <= '0;
    end else begin
      r_busy      <= (w_next != S_IDLE);
      r_min_valid <= w_commit;
      if (w_commit) begin
        r_min_hold <= r_run_min;
        r_win_num  <= r_win_num + WIN_NUM_WIDTH'(1);
      end
      if (w_alarm_set) begin
        r_alarm <= 1'b1;
      end else if (bus.alarm_clr_i) begin
        r_alarm <= 1'b0;
      end
    end
  end

  assign bus.busy_o      = r_busy;
  assign bus.min_hold_o  = r_min_hold;
  assign bus.min_valid_o = r_min_valid;
  assign bus.alarm_o     = r_alarm;
  assign bus.win_num_o   = r_win_num;

`ifdef ADC_MIN_WINDOW_MAX_EN
  logic [ADC_DATA_WIDTH-1:0] r_run_max;
  logic [ADC_DATA_WIDTH-1:0] r_max_hold;
  logic                      r_over_alarm;
  logic                      w_over_set;

  assign w_over_set = w_commit && (r_run_max > bus.thresh_hi_i);

  // Maximum path mirrors the minimum path cycle for cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run_max    <= '0;
      r_max_hold   <= '0;
      r_over_alarm <= 1'b0;
    end else begin
      if (r_state == S_ACCUM) begin
        r_run_max <= r_first ? bus.adc_min_i : f_max(r_run_max, bus.adc_min_i);
      end
      if (w_commit) begin
        r_max_hold <= r_run_max;
      end
      if (w_over_set) begin
        r_over_alarm <= 1'b1;
      end else if (bus.alarm_clr_i) begin
        r_over_alarm <= 1'b0;
      end
    end
  end

  assign bus.max_hold_o   = r_max_hold;
  assign bus.over_alarm_o = r_over_alarm;
`endif

endmodule
